// File: rtl/sequence_signal_generator.sv
// Serial sequence generator: emits SEQ_PATTERN one bit per clock, MSB first,
// repeating with no idle cycle between periods. The rstn input is an
// active-high synchronous reset; the name is kept as in the surrounding code.
module sequence_signal_generator #(
    parameter int                 SEQ_LEN     = 8,
    parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = 8'b1110_0010
) (
    input  logic clk,
    input  logic rstn,
    output logic out
);

    localparam int               IDX_W    = $clog2(SEQ_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);

    // Reverse the pattern once so the index selects the bit to emit directly:
    // index 0 picks the MSB of SEQ_PATTERN.
    function automatic logic [SEQ_LEN-1:0] reverse_bits(input logic [SEQ_LEN-1:0] v);
        logic [SEQ_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            r[i] = v[SEQ_LEN-1-i];
        end
        return r;
    endfunction

    localparam logic [SEQ_LEN-1:0] PATTERN_REV = reverse_bits(SEQ_PATTERN);

    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] index_d;
    logic             out_q;
    logic             out_d;

    // Next-state: pick the current pattern bit and advance the index,
    // wrapping explicitly at SEQ_LEN-1 so non-power-of-two lengths never
    // reach an illegal index.
    always_comb begin
        index_d = (index_q == IDX_LAST) ? {IDX_W{1'b0}} : (index_q + IDX_W'(1));
        out_d   = PATTERN_REV[index_q];
    end

    // State register with synchronous active-high reset taking priority.
    always_ff @(posedge clk) begin
        if (rstn) begin
            index_q <= {IDX_W{1'b0}};
            out_q   <= 1'b0;
        end else begin
            index_q <= index_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_sequence_signal_generator.sv
// Scoreboard bench: stimulus pushes hand-tabulated expected bits into
// per-instance queues, a monitor pops and compares after every rising edge.
module tb_sequence_signal_generator;

    logic clk;
    logic rstn;
    logic out8;
    logic out5;

    int vectors;
    int miscompares;

    logic q8[$];
    logic q5[$];

    // Hand-computed expected sequences (MSB-first reading of each pattern).
    logic exp8[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp5[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    int k8;
    int k5;

    logic mon_e8;
    logic mon_e5;

    sequence_signal_generator dut8 (
        .clk  (clk),
        .rstn (rstn),
        .out  (out8)
    );

    sequence_signal_generator #(
        .SEQ_LEN     (5),
        .SEQ_PATTERN (5'b10011)
    ) dut5 (
        .clk  (clk),
        .rstn (rstn),
        .out  (out5)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare each instance against the head of its queue.
    always @(posedge clk) begin
        #1;
        if (q8.size() != 0) begin
            mon_e8 = q8.pop_front();
            vectors++;
            if (out8 !== mon_e8) begin
                miscompares++;
                $display("FAIL seq8 vec %0d t=%0t: got %b, expected %b", vectors, $time, out8, mon_e8);
            end
        end
        if (q5.size() != 0) begin
            mon_e5 = q5.pop_front();
            vectors++;
            if (out5 !== mon_e5) begin
                miscompares++;
                $display("FAIL seq5 vec %0d t=%0t: got %b, expected %b", vectors, $time, out5, mon_e5);
            end
        end
    end

    // Drive rstn for the next edge (optionally with a sub-cycle glitch that
    // does not span an edge) and push the expected outputs.
    task automatic step(input logic rst, input logic glitch);
        @(negedge clk);
        rstn = rst;
        if (rst) begin
            k8 = 0;
            k5 = 0;
            q8.push_back(1'b0);
            q5.push_back(1'b0);
        end else begin
            q8.push_back(exp8[k8 % 8]);
            q5.push_back(exp5[k5 % 5]);
            k8++;
            k5++;
        end
        if (glitch) begin
            #1 rstn = 1'b1;
            #2 rstn = 1'b0;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        k8          = 0;
        k5          = 0;
        rstn        = 1'b1;

        // Reset held 2 edges, then release and run 24 clocks (3 default periods).
        repeat (2) step(1'b1, 1'b0);
        repeat (24) step(1'b0, 1'b0);

        // Mid-sequence reset after release edge 5, then restart.
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);

        // Sustained reset for 10 edges, then release.
        repeat (10) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);

        // Sub-cycle glitches between edges must not disturb the sequence.
        repeat (2) step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(posedge clk);
        #2;
        if (q8.size() != 0 || q5.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q8.size(), q5.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sequence_signal_generator.md
SEQUENCE_SIGNAL_GENERATOR -- requirements
Module: sequence_signal_generator

Interface
REQ-001 The block SHALL have parameter SEQ_LEN, default 8, giving the number of bits in one sequence period (legal range 2..32).
REQ-002 The block SHALL have parameter SEQ_PATTERN, width SEQ_LEN, default 8'b1110_0010, giving the serial pattern to emit, MSB first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-high (rstn=1 resets on the next rising clk edge; the name is kept as in the codebase).
REQ-005 The block SHALL have port out, output, 1 bit: registered serial sequence bit.

Function
REQ-006 The block SHALL contain an index register of width ceil(log2(SEQ_LEN)) that selects the pattern bit to emit next.
REQ-007 When rstn=0 at a rising edge, out SHALL be loaded with SEQ_PATTERN[SEQ_LEN-1-index].
- On that same edge, index SHALL advance by 1.
REQ-008 When index equals SEQ_LEN-1 and rstn=0 at a rising edge, index SHALL wrap to 0.
- No idle cycle SHALL occur between periods; the sequence period is exactly SEQ_LEN clocks.
REQ-009 Index arithmetic SHALL never reach values >= SEQ_LEN, including when SEQ_LEN is not a power of two.
REQ-010 out SHALL be driven directly from a flip-flop, with no combinational path from rstn to out.
REQ-011 Latency: the first clk edge with rstn=0 after reset SHALL produce out = SEQ_PATTERN[SEQ_LEN-1].
- Edge k (k=1,2,...) SHALL produce SEQ_PATTERN[SEQ_LEN-1-((k-1) mod SEQ_LEN)].
REQ-012 With default parameters, out SHALL repeat 1,1,1,0,0,0,1,0 on consecutive clocks after reset release.
REQ-013 out SHALL depend only on index and SEQ_PATTERN; there are no other inputs or enables.
REQ-014 Before the first reset, out and index are undefined; verification SHALL NOT check outputs before the first reset edge.

Reset
REQ-015 On any rising edge with rstn=1, index SHALL be set to 0 and out SHALL be set to 0.
REQ-016 Reset SHALL take priority over the sequence advance, regardless of the current index (reset mid-period).
REQ-017 Holding rstn=1 for N edges SHALL keep out=0 and index=0 for all N edges.
REQ-018 Reset pulses shorter than one clock that do not span a rising edge SHALL have no effect.
REQ-019 After reset deasserts, the sequence SHALL restart from the MSB per REQ-011.

Verification
REQ-020 Reset then release: hold rstn=1 for 2 edges, then rstn=0 -> out=0 during reset, then 1,1,1,0,0,0,1,0 on edges 1-8 after release.
REQ-021 Wrap-around: run 24 clocks after release -> the 8-bit default pattern appears exactly 3 times with no gap or glitch at the period boundaries.
REQ-022 Mid-sequence reset: assert rstn=1 for one edge after release edge 5 -> out=0 on that edge, then out restarts 1,1,1,0,... on the next edges.
REQ-023 Sustained reset: rstn=1 for 10 edges -> out=0 on every edge and no advance; the first post-release bit is 1.
REQ-024 Parameter override: SEQ_LEN=5, SEQ_PATTERN=5'b10011 -> out repeats 1,0,0,1,1 with a period of 5 clocks.
REQ-025 Sub-cycle reset glitch: rstn pulses high between edges only -> the sequence continues uninterrupted.
